// File: rtl/core_if_arbiter.sv
// -----------------------------------------------------------------------------
// core_if_arbiter
// N-port arbiter for the core memory protocol (req/gnt/rvalid/we/be/addr/
// wdata/rdata/err). Several masters share one slave port. Granted requests
// are remembered as port IDs in a small in-order FIFO, so each slave response
// is steered back to the master that issued it.
//
// Configuration macro:
//   CORE_ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 highest
//                           undefined -> round-robin (default)
//
// m_gnt, m_rvalid, m_rdata, m_err and the slave request side are
// combinational, because the protocol needs a 0-cycle grant and a same-cycle
// response. They are also forced to 0 while rst_n is low, so every output
// clears as soon as reset asserts.
// -----------------------------------------------------------------------------
module core_if_arbiter #(
   parameter int N_PORTS   = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   // master side
   input  logic [N_PORTS-1:0]              m_req,
   output logic [N_PORTS-1:0]              m_gnt,
   output logic [N_PORTS-1:0]              m_rvalid,
   input  logic [N_PORTS-1:0]              m_we,
   input  logic [N_PORTS*(DATA_W/8)-1:0]   m_be,
   input  logic [N_PORTS*ADDR_W-1:0]       m_addr,
   input  logic [N_PORTS*DATA_W-1:0]       m_wdata,
   output logic [DATA_W-1:0]               m_rdata,
   output logic                            m_err,
   // slave side
   output logic                            s_req,
   output logic                            s_we,
   output logic [(DATA_W/8)-1:0]           s_be,
   output logic [ADDR_W-1:0]               s_addr,
   output logic [DATA_W-1:0]               s_wdata,
   input  logic                            s_gnt,
   input  logic                            s_rvalid,
   input  logic [DATA_W-1:0]               s_rdata,
   input  logic                            s_err,
   // status
   output logic                            protocol_err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int ID_W  = $clog2(N_PORTS);
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // FIFO pointer increment that wraps at MAX_OUTST-1, not at 2**PTR_W-1
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(MAX_OUTST - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Port index increment that wraps at N_PORTS-1
   function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
      logic [ID_W-1:0] nxt;
      if (id == ID_W'(N_PORTS - 1)) begin
         nxt = '0;
      end else begin
         nxt = id + ID_W'(1);
      end
      return nxt;
   endfunction

   // ---------------------------------------------------------------------
   // Unpacked views of the master payload buses
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_arr_s  [N_PORTS];
   logic [DATA_W-1:0] wdata_arr_s [N_PORTS];
   logic [BE_W-1:0]   be_arr_s    [N_PORTS];

   for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
      assign addr_arr_s[g]  = m_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr_s[g] = m_wdata[g*DATA_W +: DATA_W];
      assign be_arr_s[g]    = m_be[g*BE_W +: BE_W];
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e             state_r;
   state_e             state_nxt_s;
   logic [ID_W-1:0]    hold_id_r;
   logic [ID_W-1:0]    fifo_mem_r [MAX_OUTST];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               protocol_err_r;

   logic               win_found_s;
   logic [ID_W-1:0]    win_id_s;
   logic [ID_W-1:0]    sel_id_s;
   logic               sel_valid_s;
   logic               can_issue_s;
   logic               s_req_s;
   logic               accept_s;
   logic               fifo_empty_s;
   logic               pop_s;
   logic [ID_W-1:0]    head_id_s;

`ifdef CORE_ARB_FIXED_PRIO_EN
   // Fixed priority: lowest-index requesting port wins
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = '0;
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (m_req[ID_W'(i)]) begin
            win_found_s = 1'b1;
            win_id_s    = ID_W'(i);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end
`else
   localparam int IDX_W = ID_W + 1;

   logic [ID_W-1:0]  rr_ptr_r;
   logic [IDX_W-1:0] sum_s;
   logic [IDX_W-1:0] cand_s;

   // Round-robin: first requesting port at or after rr_ptr_r, modulo N_PORTS
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = '0;
      sum_s       = '0;
      cand_s      = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         sum_s  = {1'b0, rr_ptr_r} + IDX_W'(i);
         cand_s = (sum_s >= IDX_W'(N_PORTS)) ? (sum_s - IDX_W'(N_PORTS)) : sum_s;
         if (!win_found_s && m_req[cand_s[ID_W-1:0]]) begin
            win_found_s = 1'b1;
            win_id_s    = cand_s[ID_W-1:0];
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Round-robin pointer moves just past the port that was accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
      end else if (accept_s) begin
         rr_ptr_r <= id_inc(sel_id_s);
      end
   end
`endif

   // ---------------------------------------------------------------------
   // FSM: ARB picks a winner each cycle, HOLD freezes it until granted
   // ---------------------------------------------------------------------

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_ARB;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ARB: begin
            if (s_req_s && !s_gnt) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_ARB;
            end
         end
         ST_HOLD: begin
            // A held master that withdraws (contract breach) also releases HOLD
            if (accept_s || !sel_valid_s) begin
               state_nxt_s = ST_ARB;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: state_nxt_s = ST_ARB;
      endcase
   end

   // FSM output logic: which port drives the slave request this cycle
   always_comb begin
      sel_id_s    = win_id_s;
      sel_valid_s = win_found_s;
      case (state_r)
         ST_ARB: begin
            sel_id_s    = win_id_s;
            sel_valid_s = win_found_s;
         end
         ST_HOLD: begin
            sel_id_s    = hold_id_r;
            sel_valid_s = m_req[hold_id_r];
         end
         default: begin
            sel_id_s    = win_id_s;
            sel_valid_s = win_found_s;
         end
      endcase
   end

   // Latch the ARB winner when the slave stalls it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_id_r <= '0;
      end else if (state_r == ST_ARB && s_req_s && !s_gnt) begin
         hold_id_r <= win_id_s;
      end
   end

   // A full FIFO blocks new requests even if a pop happens in the same cycle
   assign can_issue_s  = (count_r < CNT_W'(MAX_OUTST));
   assign s_req_s      = rst_n & sel_valid_s & can_issue_s;
   assign accept_s     = s_req_s & s_gnt;
   assign fifo_empty_s = (count_r == '0);
   assign pop_s        = rst_n & s_rvalid & ~fifo_empty_s;
   assign head_id_s    = fifo_mem_r[rd_ptr_r];

   // ---------------------------------------------------------------------
   // Slave request side
   // ---------------------------------------------------------------------

   // Slave request and payload from the selected port, zero when idle
   always_comb begin
      s_req   = s_req_s;
      s_we    = 1'b0;
      s_be    = '0;
      s_addr  = '0;
      s_wdata = '0;
      if (s_req_s) begin
         s_we    = m_we[sel_id_s];
         s_be    = be_arr_s[sel_id_s];
         s_addr  = addr_arr_s[sel_id_s];
         s_wdata = wdata_arr_s[sel_id_s];
      end else begin
         s_we    = 1'b0;
         s_be    = '0;
         s_addr  = '0;
         s_wdata = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Master grant / response side
   // ---------------------------------------------------------------------

   // One-hot grant to the accepted port, same cycle as s_gnt
   always_comb begin
      m_gnt = '0;
      if (accept_s) begin
         m_gnt[sel_id_s] = 1'b1;
      end else begin
         m_gnt = '0;
      end
   end

   // One-hot response valid to the oldest outstanding issuer
   always_comb begin
      m_rvalid = '0;
      if (pop_s) begin
         m_rvalid[head_id_s] = 1'b1;
      end else begin
         m_rvalid = '0;
      end
   end

   assign m_rdata      = rst_n ? s_rdata : '0;
   assign m_err        = rst_n & s_err;
   assign protocol_err = protocol_err_r;

   // ---------------------------------------------------------------------
   // Outstanding-ID FIFO
   // ---------------------------------------------------------------------

   // ID storage: write the accepted port at the write pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            fifo_mem_r[i] <= '0;
         end
      end else if (accept_s) begin
         fifo_mem_r[wr_ptr_r] <= sel_id_s;
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (accept_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky flag: slave answered with nothing outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         protocol_err_r <= 1'b0;
      end else if (s_rvalid && fifo_empty_s) begin
         protocol_err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_core_if_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_if_arbiter
// Directed stimulus for core_if_arbiter (2 ports, 32-bit, MAX_OUTST=2).
// Expected responses are queued when a request is issued; a monitor pops and
// compares whenever the DUT raises m_rvalid.
// -----------------------------------------------------------------------------
module tb_core_if_arbiter;

   localparam int N_PORTS   = 2;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_OUTST = 2;
   localparam int BE_W      = DATA_W / 8;

`ifdef CORE_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [N_PORTS-1:0]          m_req;
   logic [N_PORTS-1:0]          m_gnt;
   logic [N_PORTS-1:0]          m_rvalid;
   logic [N_PORTS-1:0]          m_we;
   logic [N_PORTS*BE_W-1:0]     m_be;
   logic [N_PORTS*ADDR_W-1:0]   m_addr;
   logic [N_PORTS*DATA_W-1:0]   m_wdata;
   logic [DATA_W-1:0]           m_rdata;
   logic                        m_err;
   logic                        s_req;
   logic                        s_we;
   logic [BE_W-1:0]             s_be;
   logic [ADDR_W-1:0]           s_addr;
   logic [DATA_W-1:0]           s_wdata;
   logic                        s_gnt;
   logic                        s_rvalid;
   logic [DATA_W-1:0]           s_rdata;
   logic                        s_err;
   logic                        protocol_err;

   typedef struct packed {
      logic [1:0]  onehot;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   rsp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   core_if_arbiter #(
      .N_PORTS  (N_PORTS),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_OUTST(MAX_OUTST)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m_req       (m_req),
      .m_gnt       (m_gnt),
      .m_rvalid    (m_rvalid),
      .m_we        (m_we),
      .m_be        (m_be),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_err       (m_err),
      .s_req       (s_req),
      .s_we        (s_we),
      .s_be        (s_be),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_gnt       (s_gnt),
      .s_rvalid    (s_rvalid),
      .s_rdata     (s_rdata),
      .s_err       (s_err),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] onehot(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic push_exp(input int p, input logic [31:0] data, input logic err);
      rsp_t r;
      r.onehot = onehot(p);
      r.data   = data;
      r.err    = err;
      exp_q.push_back(r);
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every m_rvalid must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && m_rvalid !== 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("rvalid_unexpected", {62'd0, m_rvalid}, 64'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_port",  {62'd0, m_rvalid}, {62'd0, e.onehot});
            chk("rsp_rdata", {32'd0, m_rdata},  {32'd0, e.data});
            chk("rsp_err",   {63'd0, m_err},    {63'd0, e.err});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int pa, pb, pc;
      rst_n    = 1'b1;
      m_req    = 2'b00;
      m_we     = 2'b00;
      m_be     = {4'hF, 4'hF};
      m_addr   = '0;
      m_wdata  = '0;
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = '0;
      s_err    = 1'b0;

      // ---- reset state, with requests pending ----
      #2 rst_n = 1'b0;
      m_req  = 2'b11;
      m_addr = {32'h0000_0300, 32'h0000_0200};
      @(negedge clk);
      chk("rst_s_req",    {63'd0, s_req},        64'd0);
      chk("rst_m_gnt",    {62'd0, m_gnt},        64'd0);
      chk("rst_m_rvalid", {62'd0, m_rvalid},     64'd0);
      chk("rst_s_addr",   {32'd0, s_addr},       64'd0);
      chk("rst_perr",     {63'd0, protocol_err}, 64'd0);
      m_req = 2'b00;
      cyc();
      rst_n = 1'b1;

      // ---- single port read, response 2 cycles after grant ----
      m_req  = 2'b01;
      m_addr = {32'h0, 32'h0000_0100};
      s_gnt  = 1'b1;
      push_exp(0, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      chk("single_gnt",   {62'd0, m_gnt},  64'd1);
      chk("single_sreq",  {63'd0, s_req},  64'd1);
      chk("single_saddr", {32'd0, s_addr}, 64'h100);
      chk("single_swe",   {63'd0, s_we},   64'd0);
      cyc();
      m_req = 2'b00;
      s_gnt = 1'b0;
      @(negedge clk);
      chk("single_gnt_pulse", {62'd0, m_gnt}, 64'd0);
      cyc();
      s_rvalid = 1'b1;
      s_rdata  = 32'hDEAD_BEEF;
      cyc();
      s_rvalid = 1'b0;

      // ---- round-robin from a fresh pointer ----
      rst_n = 1'b0;
      cyc();
      rst_n  = 1'b1;
      m_req  = 2'b11;
      m_addr = {32'h0000_0300, 32'h0000_0200};
      s_gnt  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p        = FIXED ? 0 : (i % 2);
         s_rvalid = (i > 0);
         s_rdata  = 32'hA000_0000 + 32'(i) - 32'd1;
         push_exp(p, 32'hA000_0000 + 32'(i), 1'b0);
         @(negedge clk);
         chk("rr_gnt",   {62'd0, m_gnt},  {62'd0, onehot(p)});
         chk("rr_saddr", {32'd0, s_addr}, (p == 0) ? 64'h200 : 64'h300);
         cyc();
      end
      m_req    = 2'b00;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      s_rdata  = 32'hA000_0003;
      cyc();
      s_rvalid = 1'b0;

      // ---- HOLD stability: port 1 write stalled, port 0 arrives later ----
      m_req   = 2'b10;
      m_we    = 2'b10;
      m_be    = {4'hC, 4'hF};
      m_addr  = {32'h0000_0400, 32'h0000_0500};
      m_wdata = {32'hCAFE_F00D, 32'h1234_5678};
      for (int c = 0; c < 3; c++) begin
         if (c == 2) m_req = 2'b11;
         @(negedge clk);
         chk("hold_sreq",  {63'd0, s_req},   64'd1);
         chk("hold_saddr", {32'd0, s_addr},  64'h400);
         chk("hold_gnt",   {62'd0, m_gnt},   64'd0);
         cyc();
      end
      s_gnt = 1'b1;
      push_exp(1, 32'h1111_1111, 1'b0);
      @(negedge clk);
      chk("hold_gnt_p1", {62'd0, m_gnt},   64'h2);
      chk("hold_swe",    {63'd0, s_we},    64'd1);
      chk("hold_sbe",    {60'd0, s_be},    64'hC);
      chk("hold_swdata", {32'd0, s_wdata}, 64'hCAFE_F00D);
      cyc();
      m_req    = 2'b01;
      m_we     = 2'b00;
      s_rvalid = 1'b1;
      s_rdata  = 32'h1111_1111;
      push_exp(0, 32'h2222_2222, 1'b1);
      @(negedge clk);
      chk("hold_next_p0", {62'd0, m_gnt},   64'd1);
      chk("hold_p0_addr", {32'd0, s_addr},  64'h500);
      cyc();
      m_req   = 2'b00;
      s_gnt   = 1'b0;
      s_rdata = 32'h2222_2222;
      s_err   = 1'b1;
      cyc();
      s_rvalid = 1'b0;
      s_err    = 1'b0;

      // ---- full FIFO blocks s_req, no bypass on same-cycle pop ----
      pa = FIXED ? 0 : 1;
      pb = 0;
      pc = FIXED ? 0 : 1;
      m_req  = 2'b11;
      m_addr = {32'h0000_0800, 32'h0000_0700};
      s_gnt  = 1'b1;
      push_exp(pa, 32'h3333_3333, 1'b0);
      @(negedge clk);
      chk("full_gnt_a", {62'd0, m_gnt}, {62'd0, onehot(pa)});
      cyc();
      push_exp(pb, 32'h4444_4444, 1'b0);
      @(negedge clk);
      chk("full_gnt_b", {62'd0, m_gnt}, {62'd0, onehot(pb)});
      cyc();
      @(negedge clk);
      chk("full_sreq_blocked", {63'd0, s_req}, 64'd0);
      chk("full_gnt_blocked",  {62'd0, m_gnt}, 64'd0);
      cyc();
      s_rvalid = 1'b1;
      s_rdata  = 32'h3333_3333;
      @(negedge clk);
      chk("full_no_bypass", {63'd0, s_req}, 64'd0);
      cyc();
      s_rvalid = 1'b0;
      push_exp(pc, 32'h5555_5555, 1'b0);
      @(negedge clk);
      chk("full_sreq_again", {63'd0, s_req}, 64'd1);
      chk("full_gnt_c",      {62'd0, m_gnt}, {62'd0, onehot(pc)});
      cyc();
      m_req    = 2'b00;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      s_rdata  = 32'h4444_4444;
      cyc();
      s_rdata  = 32'h5555_5555;
      cyc();
      s_rvalid = 1'b0;

      // ---- response with nothing outstanding ----
      s_rvalid = 1'b1;
      s_rdata  = 32'h9999_9999;
      @(negedge clk);
      chk("perr_no_rvalid", {62'd0, m_rvalid},     64'd0);
      chk("perr_not_yet",   {63'd0, protocol_err}, 64'd0);
      cyc();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("perr_set", {63'd0, protocol_err}, 64'd1);
      cyc();
      @(negedge clk);
      chk("perr_sticky", {63'd0, protocol_err}, 64'd1);
      cyc();

      // ---- async reset mid-HOLD with one outstanding ----
      m_req  = 2'b01;
      m_addr = {32'h0000_0A00, 32'h0000_0B00};
      s_gnt  = 1'b1;
      @(negedge clk);
      chk("ar_gnt_p0", {62'd0, m_gnt}, 64'd1);
      cyc();
      m_req = 2'b10;
      s_gnt = 1'b0;
      cyc();
      @(negedge clk);
      chk("ar_hold_sreq",  {63'd0, s_req},  64'd1);
      chk("ar_hold_saddr", {32'd0, s_addr}, 64'hA00);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_sreq",   {63'd0, s_req},        64'd0);
      chk("ar_gnt",    {62'd0, m_gnt},        64'd0);
      chk("ar_saddr",  {32'd0, s_addr},       64'd0);
      chk("ar_perr",   {63'd0, protocol_err}, 64'd0);
      cyc();
      rst_n    = 1'b1;
      m_req    = 2'b00;
      s_rvalid = 1'b1;
      s_rdata  = 32'h7777_7777;
      @(negedge clk);
      chk("ar_late_no_rvalid", {62'd0, m_rvalid}, 64'd0);
      cyc();
      s_rvalid = 1'b0;
      m_req    = 2'b11;
      s_gnt    = 1'b1;
      push_exp(0, 32'h6666_6666, 1'b0);
      @(negedge clk);
      chk("ar_late_perr", {63'd0, protocol_err}, 64'd1);
      chk("ar_arb_p0",    {62'd0, m_gnt},        64'd1);
      cyc();
      m_req    = 2'b00;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      s_rdata  = 32'h6666_6666;
      cyc();
      s_rvalid = 1'b0;
      cyc();
      cyc();

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
